// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: owns the state register, decodes the latched IR
// and drives all datapath enables/selects. Perf counters built only with MC_CTRL_PERF_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IF       | fetch: request PC, load IR and PC+4 when memory is ready
// ID       | decode; ALU precomputes the branch target
// EX_R     | R-type ALU operation on regA/regB
// WB_R     | write ALUOut to rd
// EX_I     | immediate ALU operation (ADDI/ADDIU/XORI)
// WB_I     | write ALUOut to rt
// EX_ADDR  | effective address for LW/SW
// MEM_LW   | load access, held until mem_ready
// WB_LW    | write MDR to rt
// MEM_SW   | store access, held until mem_ready
// EX_BR    | BEQ/BNE compare, conditional PC write
// JUMP     | J/JR/JAL PC write
// JAL_LINK | write PC+4 to $31 before the jump
// TRAP     | undecodable instruction, one-cycle illegal pulse
module mips_mc_ctrl #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic [1:0]         pc_we,
  output logic               mem_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic               mem_in,
  output logic [1:0]         dst,
  output logic               reg_in,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic [3:0]         state_dbg,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_WB_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_WB_I     = 4'd5,
    S_EX_ADDR  = 4'd6,
    S_MEM_LW   = 4'd7,
    S_WB_LW    = 4'd8,
    S_MEM_SW   = 4'd9,
    S_EX_BR    = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL_LINK = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3);

  state_t     state;
  state_t     nxt;
  logic [5:0] op;
  logic [5:0] funct;
  logic       r_alu;
  logic       is_jr;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];
  assign r_alu       = (op == 6'h00) && (funct inside {6'h20, 6'h21, 6'h22, 6'h26, 6'h2A});
  assign is_jr       = (op == 6'h00) && (funct == 6'h08);

  always_comb begin
    nxt = S_IF;
    case (state)
      S_IF:       nxt = mem_ready ? S_ID : S_IF;
      S_ID: begin
        if (r_alu)                                  nxt = S_EX_R;
        else if (is_jr)                             nxt = S_JUMP;
        else if (op inside {6'h08, 6'h09, 6'h0E})   nxt = S_EX_I;
        else if (op inside {6'h23, 6'h2B})          nxt = S_EX_ADDR;
        else if (op inside {6'h04, 6'h05})          nxt = S_EX_BR;
        else if (op == 6'h02)                       nxt = S_JUMP;
        else if (op == 6'h03)                       nxt = S_JAL_LINK;
        else                                        nxt = S_TRAP;
      end
      S_EX_R:     nxt = S_WB_R;
      S_WB_R:     nxt = S_IF;
      S_EX_I:     nxt = S_WB_I;
      S_WB_I:     nxt = S_IF;
      S_EX_ADDR:  nxt = (op == 6'h23) ? S_MEM_LW : S_MEM_SW;
      S_MEM_LW:   nxt = mem_ready ? S_WB_LW : S_MEM_LW;
      S_WB_LW:    nxt = S_IF;
      S_MEM_SW:   nxt = mem_ready ? S_IF : S_MEM_SW;
      S_EX_BR:    nxt = S_IF;
      S_JAL_LINK: nxt = S_JUMP;
      S_JUMP:     nxt = S_IF;
      S_TRAP:     nxt = S_IF;
      default:    nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IF;
    else          state <= nxt;
  end

  // Outputs are decoded from state; holding reset_n low forces all of them to 0.
  always_comb begin
    mem_req   = 1'b0;
    pc_we     = 2'd0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_in    = 1'b0;
    dst       = 2'd0;
    reg_in    = 1'b0;
    ALUsrcA   = 1'b0;
    ALUsrcB   = 2'd0;
    ALUop     = ALU_ADD;
    pc_src    = 2'd0;
    illegal   = 1'b0;
    state_dbg = 4'd0;
    if (reset_n) begin
      state_dbg = state;
      case (state)
        S_IF: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = {1'b0, mem_ready};
        end
        S_ID: ALUsrcB = 2'd3;
        S_EX_R: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'd1;
          case (funct)
            6'h22:   ALUop = ALU_SUB;
            6'h26:   ALUop = ALU_XOR;
            6'h2A:   ALUop = ALU_SLT;
            default: ALUop = ALU_ADD;
          endcase
        end
        S_WB_R: begin
          reg_we = 1'b1;
          reg_in = 1'b1;
        end
        S_EX_I: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'd2;
          ALUop   = (op == 6'h0E) ? ALU_XOR : ALU_ADD;
        end
        S_WB_I: begin
          reg_we = 1'b1;
          dst    = 2'd1;
          reg_in = 1'b1;
        end
        S_EX_ADDR: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'd2;
        end
        S_MEM_LW: begin
          mem_req = 1'b1;
          mem_in  = 1'b1;
        end
        S_WB_LW: begin
          reg_we = 1'b1;
          dst    = 2'd1;
        end
        S_MEM_SW: begin
          mem_req = 1'b1;
          mem_in  = 1'b1;
          mem_we  = 1'b1;
        end
        S_EX_BR: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'd1;
          ALUop   = ALU_SUB;
          pc_src  = 2'd1;
          pc_we   = (op == 6'h05) ? 2'd3 : 2'd2;
        end
        S_JAL_LINK: begin
          reg_we = 1'b1;
          dst    = 2'd2;
          reg_in = 1'b1;
        end
        S_JUMP: begin
          pc_we  = 2'd1;
          pc_src = is_jr ? 2'd2 : 2'd3;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic retire;

  // TRAP returns to IF without retiring, so only the real final states count.
  assign retire = (nxt == S_IF) &&
                  (state inside {S_WB_R, S_WB_I, S_WB_LW, S_MEM_SW, S_EX_BR, S_JUMP});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomised bench for mips_mc_ctrl: each instruction is expanded into the expected
// per-cycle output sequence from the instruction-class rules and compared every cycle.
module tb_mips_mc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   instr = '0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, ir_we, reg_we, mem_in, reg_in, ALUsrcA, illegal;
  logic [1:0]    pc_we, dst, ALUsrcB, ALUop, pc_src;
  logic [3:0]    state_dbg;
  logic [CW-1:0] cycle_cnt, retire_cnt;

  mips_mc_ctrl #(.ALUOP_W(2), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_we(pc_we), .mem_we(mem_we), .ir_we(ir_we),
    .reg_we(reg_we), .mem_in(mem_in), .dst(dst), .reg_in(reg_in),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .pc_src(pc_src),
    .illegal(illegal), .state_dbg(state_dbg),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  logic [17:0] got_o;
  assign got_o = {mem_req, pc_we, mem_we, ir_we, reg_we, mem_in, dst, reg_in,
                  ALUsrcA, ALUsrcB, ALUop, pc_src, illegal};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t instr=%h)", tag, got, exp, $time, instr);
  endtask

  // Expected output word in the same field order as got_o.
  function automatic logic [17:0] ov(input logic req, input logic [1:0] pcw, input logic mw,
                                     input logic iw, input logic rw, input logic mi,
                                     input logic [1:0] d, input logic ri, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] alu,
                                     input logic [1:0] ps, input logic ill);
    return {req, pcw, mw, iw, rw, mi, d, ri, sa, sb, alu, ps, ill};
  endfunction

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic [17:0] o;
    logic        ret;
  } cyc_t;

  cyc_t scr[$];
  int   m_cyc = 0;
  int   m_ret = 0;

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef MC_CTRL_PERF_EN
    return 32'(v & ((1 << CW) - 1));
`else
    return (v >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [17:0] o, input logic ret);
    scr.push_back('{st: st, mr: mr, o: o, ret: ret});
  endtask

  task automatic build(input logic [31:0] ins, input int wif, input int wm);
    logic [5:0] op, fn;
    logic [3:0] mst;
    logic       sw;
    op = ins[31:26];
    fn = ins[5:0];
    scr.delete();
    for (int i = 0; i < wif; i++) push(4'd0, 1'b0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    push(4'd0, 1'b1, ov(1,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
    push(4'd1, rb(), ov(0,0,0,0,0,0,0,0,0,3,0,0,0), 1'b0);
    if (op == 6'h00 && (fn inside {6'h20, 6'h21, 6'h22, 6'h26, 6'h2A})) begin
      push(4'd2, rb(), ov(0,0,0,0,0,0,0,0,1,1,
                          (fn == 6'h22) ? 2'd1 : (fn == 6'h26) ? 2'd3 : (fn == 6'h2A) ? 2'd2 : 2'd0,
                          0,0), 1'b0);
      push(4'd3, rb(), ov(0,0,0,0,1,0,0,1,0,0,0,0,0), 1'b1);
    end else if (op == 6'h00 && fn == 6'h08) begin
      push(4'd11, rb(), ov(0,1,0,0,0,0,0,0,0,0,0,2,0), 1'b1);
    end else if (op inside {6'h08, 6'h09, 6'h0E}) begin
      push(4'd4, rb(), ov(0,0,0,0,0,0,0,0,1,2,(op == 6'h0E) ? 2'd3 : 2'd0,0,0), 1'b0);
      push(4'd5, rb(), ov(0,0,0,0,1,0,1,1,0,0,0,0,0), 1'b1);
    end else if (op inside {6'h23, 6'h2B}) begin
      sw  = (op == 6'h2B);
      mst = sw ? 4'd9 : 4'd7;
      push(4'd6, rb(), ov(0,0,0,0,0,0,0,0,1,2,0,0,0), 1'b0);
      for (int i = 0; i < wm; i++) push(mst, 1'b0, ov(1,0,sw,0,0,1,0,0,0,0,0,0,0), 1'b0);
      push(mst, 1'b1, ov(1,0,sw,0,0,1,0,0,0,0,0,0,0), sw);
      if (!sw) push(4'd8, rb(), ov(0,0,0,0,1,0,1,0,0,0,0,0,0), 1'b1);
    end else if (op inside {6'h04, 6'h05}) begin
      push(4'd10, rb(), ov(0,(op == 6'h05) ? 2'd3 : 2'd2,0,0,0,0,0,0,1,1,1,1,0), 1'b1);
    end else if (op == 6'h02) begin
      push(4'd11, rb(), ov(0,1,0,0,0,0,0,0,0,0,0,3,0), 1'b1);
    end else if (op == 6'h03) begin
      push(4'd12, rb(), ov(0,0,0,0,1,0,2,1,0,0,0,0,0), 1'b0);
      push(4'd11, rb(), ov(0,1,0,0,0,0,0,0,0,0,0,3,0), 1'b1);
    end else begin
      push(4'd13, rb(), ov(0,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0);
    end
  endtask

  // Entered and left at posedge+1; nmax < 0 runs the whole script.
  task automatic run(input int nmax);
    int n;
    n = (nmax < 0) ? scr.size() : nmax;
    for (int i = 0; i < n; i++) begin
      mem_ready = scr[i].mr;
      #2;
      chk("outputs", 32'(got_o), 32'(scr[i].o));
      chk("state", 32'(state_dbg), 32'(scr[i].st));
      chk("cycle_cnt", 32'(cycle_cnt), exp_cnt(m_cyc));
      chk("retire_cnt", 32'(retire_cnt), exp_cnt(m_ret));
      @(posedge clk);
      #1;
      m_cyc++;
      if (scr[i].ret) m_ret++;
    end
  endtask

  task automatic do_instr(input logic [31:0] ins, input int wif, input int wm);
    instr = ins;
    build(ins, wif, wm);
    run(-1);
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [5:0]  op;
    logic [5:0]  rfn[5] = '{6'h20, 6'h21, 6'h22, 6'h26, 6'h2A};
    logic [5:0]  iop[3] = '{6'h08, 6'h09, 6'h0E};
    r = $urandom;
    case ($urandom_range(0, 10))
      0:  return {6'h00, r[25:6], rfn[$urandom_range(0, 4)]};
      1:  return {6'h00, r[25:6], 6'h08};
      2:  return {iop[$urandom_range(0, 2)], r[25:0]};
      3:  return {6'h23, r[25:0]};
      4:  return {6'h2B, r[25:0]};
      5:  return {6'h04, r[25:0]};
      6:  return {6'h05, r[25:0]};
      7:  return {6'h02, r[25:0]};
      8:  return {6'h03, r[25:0]};
      9: begin
        do op = 6'($urandom_range(1, 63));
        while (op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0E, 6'h23, 6'h2B});
        return {op, r[25:0]};
      end
      default: return {6'h00, r[25:6], 6'h00};
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_outs"}, 32'(got_o), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    chk({tag, "_retire_cnt"}, 32'(retire_cnt), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    reset_n = 1'b1;

    do_instr(32'h00221820, 0, 0);   // ADD $3,$1,$2
    do_instr(32'h8C220004, 0, 3);   // LW with three wait cycles
    do_instr(32'h14220003, 1, 0);   // BNE
    do_instr(32'h10220003, 0, 0);   // BEQ
    do_instr(32'h0C000010, 0, 0);   // JAL
    do_instr(32'hFC000000, 0, 0);   // opcode 0x3F traps
    do_instr(32'h03E00008, 2, 0);   // JR $31
    do_instr(32'h38220055, 0, 0);   // XORI

    repeat (300) do_instr(gen(), $urandom_range(0, 2), $urandom_range(0, 3));

    // Reset asserted while a store is waiting in MEM_SW.
    instr = 32'hAC220008;
    build(instr, 1, 5);
    run(5);
    chk("in_mem_sw", 32'(state_dbg), 32'd9);
    mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_reset("mid_sw_reset");
    @(posedge clk);
    #1 chk_reset("held_reset");
    reset_n = 1'b1;
    m_cyc = 0;
    m_ret = 0;

    scr.delete();
    for (int i = 0; i < 16; i++) push(4'd0, 1'b0, ov(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    run(-1);
    #2 chk("cycle_wrap", 32'(cycle_cnt), exp_cnt(m_cyc));
    do_instr(32'h00221822, 0, 0);   // SUB after the wrap

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
